// File: rtl/bcd_pkg.sv
// Shared types and constants for the parameterised binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int ADD3_THRESH = 5;
  localparam int ADD3_VAL    = 3;

  // ceil(width * log10(2)), with log10(2) approximated as 0.30103
  function automatic int bcd_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One double-dabble cell: add 3 to a digit >= 5, then shift left one bit.
module bcd_digit_step
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  input  logic       carry_in,
  output logic [3:0] digit_out,
  output logic       carry_out
);

  logic [3:0] adj;

  always_comb begin
    adj = digit_in;
    if (digit_in >= 4'(ADD3_THRESH)) adj = digit_in + 4'(ADD3_VAL);
  end

  assign digit_out = {adj[2:0], carry_in};
  assign carry_out = adj[3];

endmodule

// File: rtl/bin2bcd_param.sv
// Sequential double-dabble converter: one bit per cycle, optional
// two's-complement input, result held in DONE until downstream accepts.
module bin2bcd_param
  import bcd_pkg::*;
#(
  parameter int BIN_W     = 16,
  parameter int DIGITS    = 5,
  parameter int SIGNED_EN = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [BIN_W-1:0]      i_binary,
  input  logic                  i_signed,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_neg,
  output logic [1:0]            o_dbg_state
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  generate
    if (DIGITS < bcd_digits(BIN_W)) begin : g_digits_too_small
      $error("bin2bcd_param: DIGITS too small for BIN_W");
    end
  endgenerate

  state_t             state;
  logic [CNT_W-1:0]   step_cnt;
  logic [BCD_W-1:0]   digits_q;
  logic [BIN_W-1:0]   mag_q;
  logic               sign_q;

  logic               neg_in;
  logic [BIN_W-1:0]   mag_in;
  logic [BCD_W-1:0]   digits_next;
  logic [DIGITS:0]    carry;
  logic               overflow_unused;

  // Handshakes: a request transfers on a rising edge with i_valid && o_ready,
  // a result transfers on a rising edge with o_valid && i_ready; inputs are
  // don't-care outside those edges and nothing is queued.
  assign o_ready     = (state == IDLE);
  assign o_valid     = (state == DONE);
  assign o_dbg_state = state;

  assign neg_in = (SIGNED_EN != 0) && i_signed && i_binary[BIN_W-1];
  assign mag_in = neg_in ? ((~i_binary) + BIN_W'(1)) : i_binary;

  assign carry[0]        = mag_q[BIN_W-1];
  assign overflow_unused = carry[DIGITS];

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_step
      bcd_digit_step u_step (
        .digit_in  (digits_q[4*g +: 4]),
        .carry_in  (carry[g]),
        .digit_out (digits_next[4*g +: 4]),
        .carry_out (carry[g+1])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      step_cnt <= '0;
      digits_q <= '0;
      mag_q    <= '0;
      sign_q   <= 1'b0;
      o_bcd    <= '0;
      o_neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            mag_q    <= mag_in;
            sign_q   <= neg_in;
            digits_q <= '0;
            step_cnt <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // After BIN_W steps, one extra cycle publishes the digits.
          if (step_cnt == CNT_W'(BIN_W)) begin
            o_bcd <= digits_q;
            o_neg <= sign_q;
            state <= DONE;
          end else begin
            digits_q <= digits_next;
            mag_q    <= {mag_q[BIN_W-2:0], 1'b0};
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (i_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_param.sv
// Bench for bin2bcd_param: main 16-bit signed build plus an unsigned build
// and an 8-bit build sharing the same request/response stimulus.
module tb_bin2bcd_param;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid = 1'b0;
  logic        i_signed = 1'b0;
  logic        i_ready = 1'b1;
  logic [15:0] i_binary = '0;

  logic        o_ready, o_valid, o_neg;
  logic [19:0] o_bcd;
  logic [1:0]  o_dbg_state;
  logic        us_o_ready, us_o_valid, us_o_neg;
  logic [19:0] us_o_bcd;
  logic [1:0]  us_o_dbg_state;
  logic        b8_o_ready, b8_o_valid, b8_o_neg;
  logic [11:0] b8_o_bcd;
  logic [1:0]  b8_o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_results = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_us_q[$];
  logic [63:0] exp_b8_q[$];

  always #5 i_clk = ~i_clk;

  bin2bcd_param #(.BIN_W(16), .DIGITS(5), .SIGNED_EN(1)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_binary(i_binary), .i_signed(i_signed), .o_valid(o_valid),
    .i_ready(i_ready), .o_bcd(o_bcd), .o_neg(o_neg), .o_dbg_state(o_dbg_state)
  );

  bin2bcd_param #(.BIN_W(16), .DIGITS(5), .SIGNED_EN(0)) u_dut_us (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(us_o_ready),
    .i_binary(i_binary), .i_signed(i_signed), .o_valid(us_o_valid),
    .i_ready(i_ready), .o_bcd(us_o_bcd), .o_neg(us_o_neg),
    .o_dbg_state(us_o_dbg_state)
  );

  bin2bcd_param #(.BIN_W(8), .DIGITS(3), .SIGNED_EN(1)) u_dut_b8 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(b8_o_ready),
    .i_binary(i_binary[7:0]), .i_signed(i_signed), .o_valid(b8_o_valid),
    .i_ready(i_ready), .o_bcd(b8_o_bcd), .o_neg(b8_o_neg),
    .o_dbg_state(b8_o_dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: interpret the low w bits, take the magnitude arithmetically,
  // peel decimal digits with % and /. Sign lands in bit 32.
  function automatic logic [63:0] model(input logic [15:0] bin, input logic sgn,
                                        input int w, input bit sen);
    longint unsigned v;
    logic            neg;
    logic [63:0]     r;
    v   = 64'(bin) & ((64'd1 << w) - 64'd1);
    neg = sen && sgn && (((v >> (w - 1)) & 64'd1) == 64'd1);
    if (neg) v = (64'd1 << w) - v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    r[32] = neg;
    return r;
  endfunction

  function automatic logic [63:0] pack(input logic neg, input logic [19:0] bcd);
    return (64'(neg) << 32) | 64'(bcd);
  endfunction

  always @(negedge i_clk) begin
    if (i_rst) begin
      exp_q.delete();
      exp_us_q.delete();
      exp_b8_q.delete();
    end else begin
      if (i_valid && o_ready) exp_q.push_back(model(i_binary, i_signed, 16, 1'b1));
      if (i_valid && us_o_ready) exp_us_q.push_back(model(i_binary, i_signed, 16, 1'b0));
      if (i_valid && b8_o_ready) exp_b8_q.push_back(model(i_binary, i_signed, 8, 1'b1));
      if (o_valid && i_ready) begin
        n_results++;
        if (exp_q.size() == 0) check("main_unexpected_result", 64'd1, 64'd0);
        else check("main_sb", pack(o_neg, o_bcd), exp_q.pop_front());
      end
      if (us_o_valid && i_ready) begin
        if (exp_us_q.size() == 0) check("us_unexpected_result", 64'd1, 64'd0);
        else check("us_sb", pack(us_o_neg, us_o_bcd), exp_us_q.pop_front());
      end
      if (b8_o_valid && i_ready) begin
        if (exp_b8_q.size() == 0) check("b8_unexpected_result", 64'd1, 64'd0);
        else check("b8_sb", pack(b8_o_neg, {8'd0, b8_o_bcd}), exp_b8_q.pop_front());
      end
    end
  end

  task automatic send(input logic [15:0] b, input logic s);
    int budget = 0;
    @(posedge i_clk); #1;
    while (!o_ready && budget < 100) begin
      @(posedge i_clk); #1;
      budget++;
    end
    if (!o_ready) check("send_ready_timeout", 64'd0, 64'd1);
    i_binary = b;
    i_signed = s;
    i_valid  = 1'b1;
    @(posedge i_clk); #1;
    i_valid  = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (edges < 200) begin
      @(posedge i_clk);
      edges++;
      #1;
      if (o_valid) break;
    end
    if (!o_valid) check("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_one(input string tag, input logic [15:0] b, input logic s,
                         input logic [19:0] exp_bcd, input logic exp_neg);
    int e;
    send(b, s);
    wait_valid(e);
    check({tag, "_latency"}, 64'(e), 64'd17);
    check({tag, "_bcd"}, 64'(o_bcd), 64'(exp_bcd));
    check({tag, "_neg"}, 64'(o_neg), 64'(exp_neg));
    @(posedge i_clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, n0;
    logic [15:0] rb;
    logic        rs;

    i_rst = 1'b1;
    #1;
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_bcd", 64'(o_bcd), 64'd0);
    check("rst_neg", 64'(o_neg), 64'd0);
    check("rst_state", 64'(o_dbg_state), 64'd0);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;

    run_one("u00ff", 16'h00FF, 1'b0, 20'h00255, 1'b0);
    check("hold_in_idle_ready", 64'(o_ready), 64'd1);
    check("hold_in_idle_bcd", 64'(o_bcd), 64'h00255);
    check("b8_ff_bcd", 64'(b8_o_bcd), 64'h255);
    run_one("uffff", 16'hFFFF, 1'b0, 20'h65535, 1'b0);
    run_one("s8000", 16'h8000, 1'b1, 20'h32768, 1'b1);

    send(16'hFFFF, 1'b1);
    wait_valid(e);
    check("sffff_bcd", 64'(o_bcd), 64'h00001);
    check("sffff_neg", 64'(o_neg), 64'd1);
    check("us_sffff_valid", 64'(us_o_valid), 64'd1);
    check("us_sffff_bcd", 64'(us_o_bcd), 64'h65535);
    check("us_sffff_neg", 64'(us_o_neg), 64'd0);
    @(posedge i_clk); #1;

    run_one("s0000", 16'h0000, 1'b1, 20'h00000, 1'b0);

    // Backpressure: hold the result, poke i_valid, expect exactly one result.
    i_ready = 1'b0;
    n0 = n_results;
    send(16'h1234, 1'b0);
    wait_valid(e);
    check("bp_first_bcd", 64'(o_bcd), 64'h04660);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        i_binary = 16'h0F0F;
        i_valid  = 1'b1;
      end
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      check("bp_valid", 64'(o_valid), 64'd1);
      check("bp_bcd", 64'(o_bcd), 64'h04660);
      check("bp_ready", 64'(o_ready), 64'd0);
    end
    check("bp_state", 64'(o_dbg_state), 64'd2);
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    check("bp_release_ready", 64'(o_ready), 64'd1);
    repeat (30) @(posedge i_clk);
    #1;
    check("bp_result_count", 64'(n_results - n0), 64'd1);
    check("bp_no_extra_valid", 64'(o_valid), 64'd0);

    // Reset in the middle of a conversion.
    send(16'h3039, 1'b0);
    repeat (5) @(posedge i_clk);
    #1 i_rst = 1'b1;
    #1;
    check("midrst_bcd", 64'(o_bcd), 64'd0);
    check("midrst_neg", 64'(o_neg), 64'd0);
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_ready", 64'(o_ready), 64'd1);
    @(posedge i_clk); #1 i_rst = 1'b0;
    n0 = n_results;
    repeat (25) @(posedge i_clk);
    #1;
    check("midrst_no_result", 64'(n_results - n0), 64'd0);
    run_one("rereq3039", 16'h3039, 1'b0, 20'h12345, 1'b0);

    n0 = n_results;
    run_one("same64_a", 16'h0064, 1'b0, 20'h00100, 1'b0);
    run_one("same64_b", 16'h0064, 1'b0, 20'h00100, 1'b0);
    check("same64_count", 64'(n_results - n0), 64'd2);

    for (int k = 0; k < 40; k++) begin
      rb = 16'($urandom_range(0, 65535));
      rs = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 1));
      send(rb, rs);
      wait_valid(e);
      check("rand_latency", 64'(e), 64'd17);
      check("rand_result", pack(o_neg, o_bcd), model(rb, rs, 16, 1'b1));
      if (!i_ready) begin
        repeat ($urandom_range(1, 4)) @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
      @(posedge i_clk); #1;
    end

    repeat (5) @(posedge i_clk);
    #1;
    check("main_queue_empty", 64'(exp_q.size()), 64'd0);
    check("us_queue_empty", 64'(exp_us_q.size()), 64'd0);
    check("b8_queue_empty", 64'(exp_b8_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_param.md
BIN2BCD_PARAM -- requirements
Module: bin2bcd_param

Interface
REQ-001 SHALL have parameter BIN_W, default 16, binary input width (>= 4).
REQ-002 SHALL have parameter DIGITS, default 5, number of BCD output digits.
REQ-003 SHALL have parameter SIGNED_EN, default 1; 1 enables the two's-complement input mode.
REQ-004 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_valid  input  1  request valid.
REQ-007 SHALL have port o_ready  output  1  converter can accept a request.
REQ-008 SHALL have port i_binary  input  BIN_W  value to convert.
REQ-009 SHALL have port i_signed  input  1  per-request mode; 1 means i_binary is two's complement.
REQ-010 SHALL have port o_valid  output  1  result valid.
REQ-011 SHALL have port i_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port o_bcd  output  4*DIGITS  result; digit 0 (ones) in bits [3:0].
REQ-013 SHALL have port o_neg  output  1  sign of the result, 1 means negative.

Function
REQ-014 SHALL implement an FSM with states IDLE, SHIFT, DONE; o_ready = (state == IDLE); o_valid = (state == DONE).
REQ-015 SHALL accept a request on a rising edge where i_valid and o_ready are both 1, capturing i_binary and i_signed, then going IDLE -> SHIFT.
REQ-016 SHALL capture the magnitude: when SIGNED_EN = 1, i_signed = 1 and the MSB is 1, the two's-complement negation, unsigned on BIN_W bits, with sign = 1; otherwise i_binary with sign = 0.
REQ-017 SHALL ignore i_signed when SIGNED_EN = 0, and o_neg SHALL then stay 0.
REQ-018 SHALL do one double-dabble step per SHIFT cycle: add 3 to every digit >= 5, then shift {digits, magnitude} left by 1.
REQ-019 SHALL perform exactly BIN_W steps, using a step counter of width clog2(BIN_W+1), then go SHIFT -> DONE.
REQ-020 SHALL assert o_valid exactly BIN_W+1 rising edges after the accepting edge.
REQ-021 SHALL load o_bcd and o_neg only on entry to DONE, and SHALL hold them there until the next DONE entry, including across IDLE.
REQ-022 SHALL stay in DONE while i_ready = 0, with outputs stable (backpressure), and SHALL go DONE -> IDLE on the edge where o_valid and i_ready are both 1.
REQ-023 SHALL ignore i_valid whenever o_ready = 0; a request is not queued.
REQ-024 SHALL convert every accepted request, including a value equal to the previous one.
REQ-025 SHALL give zero input the result o_bcd = 0 and o_neg = 0.
REQ-026 SHALL give the most-negative signed input (-2^(BIN_W-1)) magnitude 2^(BIN_W-1), with no overflow.
REQ-027 SHALL fail elaboration if DIGITS < bcd_digits(BIN_W), so upper digits are never truncated silently.

Reset
REQ-028 SHALL, while i_rst = 1, asynchronously force state IDLE, counter 0, shift register 0, o_bcd 0, o_neg 0, o_valid 0, and o_ready 1.
REQ-029 SHALL, on reset during SHIFT or DONE, discard the in-flight conversion with no o_valid; the first request after deassertion converts normally.

Structure
REQ-030 SHALL place in shared package bcd_pkg: the state enum type, constant function bcd_digits(width) = ceil(width*log10 2), and constants ADD3_THRESH = 5 and ADD3_VAL = 3.
REQ-031 SHALL use one sub-module, bcd_digit_step: a combinational add-3-then-shift cell for one digit (carry in LSB, carry out MSB), instantiated DIGITS times by generate.

Verification (BIN_W=16, DIGITS=5, SIGNED_EN=1 unless stated)
REQ-032 SHALL cover: unsigned 0x00FF -> o_bcd 0x00255, o_neg 0, o_valid exactly 17 edges after accept; then 0xFFFF -> 0x65535.
REQ-033 SHALL cover: signed 0x8000 -> o_neg 1, o_bcd 0x32768; signed 0xFFFF -> o_neg 1, 0x00001; signed 0x0000 -> o_neg 0, 0x00000.
REQ-034 SHALL cover: i_ready held 0 for 10 cycles in DONE -> o_bcd/o_valid stable, o_ready 0, a concurrent i_valid pulse is ignored with no extra result.
REQ-035 SHALL cover: reset pulsed at step 5 of converting 0x3039 -> outputs 0 and o_ready 1 immediately; a re-request of 0x3039 -> 0x12345.
REQ-036 SHALL cover: the same value 0x0064 requested twice back-to-back -> two o_valid handshakes, each 0x00100.
REQ-037 SHALL cover: SIGNED_EN=0 build with i_signed=1, input 0xFFFF -> o_neg 0, o_bcd 0x65535; and BIN_W=8, DIGITS=3 -> 0xFF gives 0x255.
